// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and per-opcode latency lookup for alu_seq.
// ALU_MUL_EN selects whether opcode 111 runs the iterative multiplier.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // Cycles from the accepting edge to the edge that raises OUT_VALID.
  function automatic int op_latency(input logic [2:0] op, input int width);
    case (op)
      OP_ADD, OP_SUB: return 2;
      OP_MUL:         return MUL_EN ? width : 1;
      default:        return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier, one partial product per cycle; the first step
// is folded into the start cycle so the full product is ready WIDTH-1 cycles later.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SC_W = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q;
  logic [SC_W-1:0]  steps;
  logic [WIDTH:0]   acc_start;
  logic [WIDTH:0]   acc_step;

  assign acc_start = b[0] ? {1'b0, a} : '0;
  assign acc_step  = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, a_q} : '0);
  assign busy      = (steps != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      steps   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else if (start) begin
      a_q     <= a;
      product <= {acc_start, b[WIDTH-1:1]};
      steps   <= SC_W'(WIDTH - 1);
      done    <= 1'b0;
    end else if (busy) begin
      product <= {acc_step, product[WIDTH-1:1]};
      steps   <= steps - 1'b1;
      if (steps == SC_W'(1)) done <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready on both sides and fixed per-opcode latency.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 111; otherwise 111 flags ERROR.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             ERROR,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum_w, diff_w, sll_w, srl_w;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c, err_c;
  logic               finish;

  assign IN_READY  = (state == S_IDLE);
  assign OUT_VALID = (state == S_DONE);

  assign shamt  = b_q[SHAMT_W-1:0];
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};
  // The extra bit on each shift catches the last bit shifted out (0 for amount 0).
  assign sll_w  = {1'b0, a_q} << shamt;
  assign srl_w  = {a_q, 1'b0} >> shamt;

`ifdef ALU_MUL_EN
  logic                 mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  assign mul_start = (state == S_IDLE) && IN_VALID && (SELECT == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .rst_n   (RESET),
    .start   (mul_start),
    .a       (DATA1),
    .b       (DATA2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign finish = (cnt == CNT_W'(1)) && ((op_q != OP_MUL) || (mul_done && !mul_busy));
`else
  assign finish = (cnt == CNT_W'(1));
`endif

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    case (op_q)
      OP_FWD: res_c = b_q;
      OP_ADD: {carry_c, res_c} = sum_w;
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_SUB: {carry_c, res_c} = diff_w;
      OP_SLL: {carry_c, res_c} = sll_w;
      OP_SRL: begin
        res_c   = srl_w[WIDTH:1];
        carry_c = srl_w[0];
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        res_c   = mul_prod[WIDTH-1:0];
        carry_c = |mul_prod[2*WIDTH-1:WIDTH];
`else
        err_c   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_FWD;
      RESULT <= '0;
      ZERO   <= 1'b0;
      CARRY  <= 1'b0;
      ERROR  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (IN_VALID) begin
          a_q   <= DATA1;
          b_q   <= DATA2;
          op_q  <= SELECT;
          cnt   <= CNT_W'(op_latency(SELECT, WIDTH));
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (finish) begin
            RESULT <= res_c;
            ZERO   <= (res_c == '0);
            CARRY  <= carry_c;
            ERROR  <= err_c;
            cnt    <= '0;
            state  <= S_DONE;
          end else if (cnt != CNT_W'(1)) begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: if (OUT_READY) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed table, handshake corner cases, then random ops vs a model.
// Follows ALU_MUL_EN for the expected behaviour of opcode 111.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data1 = '0, data2 = '0;
  logic [2:0] sel = '0;
  logic [7:0] result;
  logic       zero, carry, error, out_valid;
  logic       out_ready = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .DATA1(data1), .DATA2(data2), .SELECT(sel), .RESULT(result),
    .ZERO(zero), .CARRY(carry), .ERROR(error), .OUT_VALID(out_valid),
    .OUT_READY(out_ready)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, r;
    logic       c, z, e;
    int         lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, b, r,
                              input logic c, z, e, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.c = c; v.z = z; v.e = e; v.lat = lat;
    return v;
  endfunction

  // Reference arithmetic straight from the opcode definitions.
  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a8, b8);
    int a, b, s, p, r, lat;
    bit c, e;
    a = a8; b = b8; s = b % 8; r = 0; c = 0; e = 0; lat = 1;
    case (op)
      3'd0: r = b;
      3'd1: begin p = a + b; r = p % 256; c = (p > 255); lat = 2; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = (a - b + 256) % 256; c = (a < b); lat = 2; end
      3'd5: begin r = (a << s) % 256; c = (s == 0) ? 0 : ((a >> (8 - s)) & 1); end
      3'd6: begin r = a >> s; c = (s == 0) ? 0 : ((a >> (s - 1)) & 1); end
      default: begin
`ifdef ALU_MUL_EN
        p = a * b; r = p % 256; c = (p > 255); lat = 8;
`else
        e = 1;
`endif
      end
    endcase
    return mk(op, a8, b8, r[7:0], c, (r == 0), e, lat);
  endfunction

  task automatic run_op(input string tag, input vec_t v);
    int lat, g;
    g = 0;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    chk({tag, " in_ready before"}, in_ready, 1);
    data1 = v.a; data2 = v.b; sel = v.op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; data1 = ~v.a; data2 = 8'($urandom); sel = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " result"}, result, v.r);
    chk({tag, " carry"}, carry, v.c);
    chk({tag, " zero"}, zero, v.z);
    chk({tag, " error"}, error, v.e);
    chk({tag, " in_ready busy"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after hs"}, out_valid, 0);
    chk({tag, " in_ready after hs"}, in_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"}, in_ready, 1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " result"}, result, 0);
    chk({tag, " zero"}, zero, 0);
    chk({tag, " carry"}, carry, 0);
    chk({tag, " error"}, error, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int g;

    tbl[0]  = mk(3'd0, 8'h04, 8'h05, 8'h05, 0, 0, 0, 1);
    tbl[1]  = mk(3'd1, 8'h04, 8'h05, 8'h09, 0, 0, 0, 2);
    tbl[2]  = mk(3'd2, 8'h04, 8'h05, 8'h04, 0, 0, 0, 1);
    tbl[3]  = mk(3'd3, 8'h04, 8'h05, 8'h05, 0, 0, 0, 1);
    tbl[4]  = mk(3'd1, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 2);
    tbl[5]  = mk(3'd4, 8'h03, 8'h05, 8'hFE, 1, 0, 0, 2);
    tbl[6]  = mk(3'd5, 8'h81, 8'h09, 8'h02, 1, 0, 0, 1);
    tbl[7]  = mk(3'd6, 8'h81, 8'h00, 8'h81, 0, 0, 0, 1);
    tbl[8]  = mk(3'd4, 8'h05, 8'h05, 8'h00, 0, 1, 0, 2);
    tbl[9]  = mk(3'd6, 8'h81, 8'h0F, 8'h01, 0, 0, 0, 1);
`ifdef ALU_MUL_EN
    tbl[10] = mk(3'd7, 8'h10, 8'h11, 8'h10, 1, 0, 0, 8);
`else
    tbl[10] = mk(3'd7, 8'h10, 8'h11, 8'h00, 0, 1, 1, 1);
`endif

    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post reset");

    for (int i = 0; i < 11; i++) run_op($sformatf("tbl%0d", i), tbl[i]);

    // Result held under backpressure while inputs churn.
    data1 = 8'h12; data2 = 8'h34; sel = 3'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
    chk("bp out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      data1 = 8'($urandom); sel = 3'd0; in_valid = i[0];
      @(posedge clk); #1;
      chk("bp result", result, 8'h46);
      chk("bp flags", {zero, carry, error}, 3'b000);
      chk("bp out_valid held", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp hs in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp no second accept", out_valid, 0);
    chk("bp idle", in_ready, 1);

    // Reset in the middle of a multiply aborts it.
    data1 = 8'h10; data2 = 8'h11; sel = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("mid reset");
    repeat (2) @(posedge clk);
    #1 chk("in reset out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after release out_valid", out_valid, 0);
    chk("after release in_ready", in_ready, 1);
    run_op("add after reset", mk(3'd1, 8'h01, 8'h01, 8'h02, 0, 0, 0, 2));

    for (int i = 0; i < 150; i++) begin
      v = model(3'($urandom), 8'($urandom), 8'($urandom));
      run_op($sformatf("rnd%0d op%0d %0h,%0h", i, v.op, v.a, v.b), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
